// File: rtl/ifu_fetch.sv
// Single-issue instruction fetch: holds the PC, fetches one instruction, waits for commit, then steps
// to the next PC. Misaligned targets and access faults park the unit in a sticky error state.
module ifu_fetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic [31:0]     inst,
  output logic            inst_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] snpc,
  input  logic            commit,
  input  logic            jump,
  input  logic            jumpr,
  input  logic            branch,
  input  logic            br_taken,
  input  logic [XLEN-1:0] immJ,
  input  logic [XLEN-1:0] immB,
  input  logic [XLEN-1:0] immI,
  input  logic [XLEN-1:0] rs1_data,
  output logic            fetch_err,
  output logic [XLEN-1:0] err_pc
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_EXEC, S_ERR} state_t;

  state_t          state;
  logic [XLEN-1:0] npc;

  assign imem_addr = pc;
  assign snpc      = pc + XLEN'(4);

  always_comb begin
    npc = pc + XLEN'(4);
    if (jump)
      npc = pc + immJ;
    else if (jumpr)
      npc = (rs1_data + immI) & {{(XLEN-1){1'b1}}, 1'b0};
    else if (branch && br_taken)
      npc = pc + immB;
  end

  // imem_req_valid is registered, so the request appears one cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      inst           <= 32'h0000_0013;
      inst_valid     <= 1'b0;
      imem_req_valid <= 1'b0;
      fetch_err      <= 1'b0;
      err_pc         <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req_valid && imem_req_ready) begin
            imem_req_valid <= 1'b0;
            state          <= S_WAIT;
          end else begin
            imem_req_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (imem_rsp_err) begin
              fetch_err <= 1'b1;
              err_pc    <= pc;
              state     <= S_ERR;
            end else begin
              inst       <= imem_rsp_data;
              inst_valid <= 1'b1;
              state      <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (commit) begin
            inst_valid <= 1'b0;
            // no compressed instructions, so bit 1 of a target must be clear
            if (npc[1]) begin
              fetch_err <= 1'b1;
              err_pc    <= npc;
              state     <= S_ERR;
            end else begin
              pc             <= npc;
              imem_req_valid <= 1'b1;
              state          <= S_REQ;
            end
          end
        end
        default: begin
          state <= S_ERR;
        end
      endcase
    end
  end

endmodule
